match_source_unit: RTL and testbench
====================================

Name: match_source_unit

Overview:
- Producer side of the match/halt control handshake.
- Detects a fixed bit pattern in a serial input stream and drives match_signal to the match controller.
- Counts the cycles in which the controller returns enable_count.
- Raises halt_flag when the count reaches a programmed limit, and holds it until the controller acknowledges from its HALT state with clear_halt.

Parameters:
- PAT_W, 4, pattern length in bits (>=2).
- PATTERN, 4'b1011, pattern to detect; the most recent bit is the LSB.
- CNT_W, 8, width of match_count.
- HALT_LIMIT, 10, count value that raises halt_flag; legal range 1 to 2^CNT_W-1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- din_valid  input  1  din is valid this cycle.
- din  input  1  serial data bit.
- enable_count  input  1  count enable returned by the controller.
- state_in  input  2  controller state: 00 IDLE, 01 MATCH, 10 HALT.
- clear_halt  input  1  halt acknowledge request.
- match_signal  output  1  registered pattern-match indication.
- halt_flag  output  1  registered halt request.
- match_count  output  CNT_W  enabled-cycle counter.
- hist  output  PAT_W  pattern shift register, for debug.

Behaviour:
- Reset (async, active-high):
  - hist=0, fill=0, match_signal=0, halt_flag=0, match_count=0.
  - Reset may arrive at any time; all state clears immediately, with no partial pattern retained.
- Internal state fill: saturating counter 0..PAT_W, counting valid bits since reset or clear.
- Shift (only when din_valid=1 and halt_flag=0):
  - hist <= {hist[PAT_W-2:0], din}; fill increments, saturating at PAT_W.
- match_signal:
  - Registered. Updated only on edges where shifting occurs.
  - Next value = (new hist == PATTERN) && (new fill == PAT_W).
  - Held unchanged on cycles with din_valid=0.
  - Overlapping matches are detected. There is no reset of hist after a match.
  - Latency: the last pattern bit presented at edge N sets match_signal high after edge N.
- Counter:
  - On each edge with enable_count=1 and halt_flag=0, match_count <= match_count+1.
  - If the incremented value equals HALT_LIMIT, halt_flag <= 1 at the same edge.
  - match_count never exceeds HALT_LIMIT. It does not wrap.
- While halt_flag=1:
  - din_valid and enable_count are ignored.
  - match_signal is forced to 0 at the next edge.
  - hist and fill are frozen.
- Halt clear:
  - Takes effect on an edge with halt_flag=1, clear_halt=1 and state_in==2'b10.
  - Result: halt_flag <= 0, match_count <= 0, fill <= 0, hist <= 0.
  - clear_halt is ignored in any other state_in value, or when halt_flag=0.
- Simultaneous events:
  - clear_halt together with din_valid: clear wins and din is discarded.
  - enable_count on the increment that reaches HALT_LIMIT, together with din_valid: the shift still occurs on that edge. The freeze applies from the next edge.
- state_in is used only to qualify clear_halt. There is no other decode.
- Outputs change only on clk rising edges or on reset. There are no combinational input-to-output paths.

Test Plan:
1. Default parameters, after reset: din_valid=1 with din=1,0,1,1 on four consecutive edges -> match_signal=0,0,0,1 after each edge; hist=4'b1011.
2. Overlap: stream 1,0,1,1,0,1,1 -> match_signal high after bits 4 and 7, low after bits 5 and 6. With din_valid=0 between bits, match_signal holds its value.
3. Fill guard, PATTERN=4'b0001: immediately after reset, din=1 -> match_signal stays 0. Then din=0,0,0,1 -> match_signal=1 after the 4th bit.
4. Halt: enable_count=1 for 12 cycles -> match_count=1..10, halt_flag=1 after the 10th edge; count stays 10 thereafter; match_signal is 0 one edge later; din_valid stimulus leaves hist unchanged.
5. Clear qualification:
   - clear_halt=1 with state_in=01 -> no change, halt_flag stays 1.
   - clear_halt=1 with state_in=10 -> after the edge, halt_flag=0, match_count=0, hist=0.
   - Stream 1,0,1,1 then matches again after its 4th bit.
6. Reset mid-operation: assert reset asynchronously after 2 pattern bits with match_count=5 -> all outputs 0 immediately. After release, a further 1,1 does not match; a full 1,0,1,1 is required.

Source files
------------

// File: rtl/match_source_unit.sv
// Producer side of the match/halt handshake: serial pattern detector, enabled-cycle
// counter with a programmed halt limit, and a halt flag cleared from the controller's HALT state.
module match_source_unit #(
    parameter int              PAT_W      = 4,
    parameter logic [PAT_W-1:0] PATTERN   = 4'b1011,
    parameter int              CNT_W      = 8,
    parameter int              HALT_LIMIT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din,
    input  logic             enable_count,
    input  logic [1:0]       state_in,
    input  logic             clear_halt,
    output logic             match_signal,
    output logic             halt_flag,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] hist
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [1:0] ST_HALT = 2'b10;

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              match_q, match_d;
    logic              halt_q, halt_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic clear_ok;
    assign clear_ok = halt_q && clear_halt && (state_in == ST_HALT);

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        halt_d  = halt_q;
        count_d = count_q;
        if (clear_ok) begin
            // Clear wins over any din presented on the same edge.
            hist_d  = '0;
            fill_d  = '0;
            match_d = 1'b0;
            halt_d  = 1'b0;
            count_d = '0;
        end else if (halt_q) begin
            match_d = 1'b0;
        end else begin
            if (din_valid) begin
                hist_d  = {hist_q[PAT_W-2:0], din};
                fill_d  = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
                match_d = (hist_d == PATTERN) && (fill_d == FILL_W'(PAT_W));
            end
            if (enable_count) begin
                count_d = count_q + 1'b1;
                if (count_d == CNT_W'(HALT_LIMIT)) begin
                    halt_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
            halt_q  <= 1'b0;
            count_q <= '0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            halt_q  <= halt_d;
            count_q <= count_d;
        end
    end

    assign match_signal = match_q;
    assign halt_flag    = halt_q;
    assign match_count  = count_q;
    assign hist         = hist_q;

endmodule

// File: tb/tb_match_source_unit.sv
// Directed and randomized checks of match_source_unit against a bit-history model;
// a second instance uses pattern 0001 to exercise the fill guard.
module tb_match_source_unit;

    localparam int PAT_W = 4;
    localparam int CNT_W = 8;
    localparam int LIMIT = 10;
    localparam logic [3:0] PAT_A = 4'b1011;
    localparam logic [3:0] PAT_B = 4'b0001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic din_valid = 1'b0, din = 1'b0, enable_count = 1'b0, clear_halt = 1'b0;
    logic [1:0] state_in = 2'b00;

    logic             match_a, halt_a, match_b, halt_b;
    logic [CNT_W-1:0] count_a, count_b;
    logic [PAT_W-1:0] hist_a, hist_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: everything received since reset/clear, plus counter and halt.
    bit bit_q[$];
    int m_count;
    bit m_halt;
    bit m_match_a, m_match_b;

    always #5 clk = ~clk;

    match_source_unit #(.PAT_W(PAT_W), .PATTERN(PAT_A), .CNT_W(CNT_W), .HALT_LIMIT(LIMIT)) u_dut_a (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .enable_count(enable_count), .state_in(state_in), .clear_halt(clear_halt),
        .match_signal(match_a), .halt_flag(halt_a), .match_count(count_a), .hist(hist_a)
    );

    match_source_unit #(.PAT_W(PAT_W), .PATTERN(PAT_B), .CNT_W(CNT_W), .HALT_LIMIT(LIMIT)) u_dut_b (
        .clk(clk), .reset(reset), .din_valid(din_valid), .din(din),
        .enable_count(enable_count), .state_in(state_in), .clear_halt(clear_halt),
        .match_signal(match_b), .halt_flag(halt_b), .match_count(count_b), .hist(hist_b)
    );

    function automatic logic [3:0] model_hist();
        logic [3:0] h = 4'b0000;
        int n = bit_q.size();
        for (int i = 0; i < PAT_W; i++) begin
            if (n - 1 - i >= 0) h[i] = bit_q[n - 1 - i];
        end
        return h;
    endfunction

    function automatic bit model_match(logic [3:0] pat);
        return (bit_q.size() >= PAT_W) && (model_hist() == pat);
    endfunction

    task automatic model_reset();
        bit_q.delete();
        m_count = 0;
        m_halt = 1'b0;
        m_match_a = 1'b0;
        m_match_b = 1'b0;
    endtask

    task automatic model_edge(logic v, logic d, logic en, logic clr, logic [1:0] st);
        if (m_halt && clr && st == 2'b10) begin
            model_reset();
        end else if (m_halt) begin
            m_match_a = 1'b0;
            m_match_b = 1'b0;
        end else begin
            if (v) begin
                bit_q.push_back(d);
                if (bit_q.size() > 8) void'(bit_q.pop_front());
                m_match_a = model_match(PAT_A);
                m_match_b = model_match(PAT_B);
            end
            if (en) begin
                m_count++;
                if (m_count == LIMIT) m_halt = 1'b1;
            end
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ":match_a"}, 32'(match_a), 32'(m_match_a));
        check({tag, ":halt_a"},  32'(halt_a),  32'(m_halt));
        check({tag, ":count_a"}, 32'(count_a), 32'(m_count));
        check({tag, ":hist_a"},  32'(hist_a),  32'(model_hist()));
        check({tag, ":match_b"}, 32'(match_b), 32'(m_match_b));
        check({tag, ":count_b"}, 32'(count_b), 32'(m_count));
        check({tag, ":hist_b"},  32'(hist_b),  32'(model_hist()));
    endtask

    // Drive at the falling edge, apply the model at the rising edge, sample 1 ns later.
    task automatic step(string tag, logic v, logic d, logic en, logic clr, logic [1:0] st);
        @(negedge clk);
        din_valid = v; din = d; enable_count = en; clear_halt = clr; state_in = st;
        @(posedge clk);
        model_edge(v, d, en, clr, st);
        #1;
        check_all(tag);
    endtask

    task automatic send_bit(string tag, logic d);
        step(tag, 1'b1, d, 1'b0, 1'b0, 2'b00);
    endtask

    task automatic async_reset(string tag);
        @(negedge clk);
        din_valid = 1'b0; enable_count = 1'b0; clear_halt = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        check({tag, ":zero"}, 32'({match_a, halt_a, count_a, hist_a}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] stream;
        model_reset();

        // Test 1: reset state, then 1,0,1,1
        async_reset("t1_reset");
        send_bit("t1_b1", 1'b1);
        send_bit("t1_b2", 1'b0);
        send_bit("t1_b3", 1'b1);
        check("t1_b3_nomatch", 32'(match_a), 32'd0);
        send_bit("t1_b4", 1'b1);
        check("t1_match", 32'(match_a), 32'd1);
        check("t1_hist", 32'(hist_a), 32'hB);

        // Test 2: overlapping stream with idle gaps between bits
        async_reset("t2_reset");
        stream = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            send_bit("t2_bit", stream[i]);
            step("t2_idle", 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            if (i == 3 || i == 0) check("t2_match_hi", 32'(match_a), 32'd1);
            if (i == 2 || i == 1) check("t2_match_lo", 32'(match_a), 32'd0);
        end

        // Test 3: fill guard on the 0001 instance
        async_reset("t3_reset");
        send_bit("t3_b1", 1'b1);
        check("t3_guard", 32'(match_b), 32'd0);
        send_bit("t3_b2", 1'b0);
        send_bit("t3_b3", 1'b0);
        send_bit("t3_b4", 1'b0);
        send_bit("t3_b5", 1'b1);
        check("t3_match", 32'(match_b), 32'd1);

        // Test 4: halt after LIMIT enabled cycles; inputs ignored afterwards
        async_reset("t4_reset");
        send_bit("t4_p1", 1'b1); send_bit("t4_p2", 1'b0);
        for (int i = 0; i < 12; i++) begin
            step("t4_cnt", 1'b1, (i % 3 == 0), 1'b1, 1'b0, 2'b00);
            if (i == 8) check("t4_pre_halt", 32'(halt_a), 32'd0);
            if (i == 9) check("t4_halt", 32'(halt_a), 32'd1);
        end
        check("t4_count_sat", 32'(count_a), 32'd10);
        check("t4_match_forced", 32'(match_a), 32'd0);

        // Test 5: clear qualification by state_in
        step("t5_wrong_state", 1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        check("t5_still_halted", 32'(halt_a), 32'd1);
        step("t5_idle_state", 1'b1, 1'b1, 1'b0, 1'b1, 2'b00);
        step("t5_clear", 1'b1, 1'b1, 1'b0, 1'b1, 2'b10);
        check("t5_cleared", 32'({halt_a, count_a, hist_a}), 32'd0);
        send_bit("t5_b1", 1'b1); send_bit("t5_b2", 1'b0);
        send_bit("t5_b3", 1'b1); send_bit("t5_b4", 1'b1);
        check("t5_rematch", 32'(match_a), 32'd1);

        // Test 6: async reset mid-pattern with a nonzero count
        for (int i = 0; i < 5; i++) step("t6_cnt", 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        send_bit("t6_b1", 1'b1); send_bit("t6_b2", 1'b0);
        async_reset("t6_reset");
        send_bit("t6_c1", 1'b1); send_bit("t6_c2", 1'b1);
        check("t6_no_partial", 32'(match_a), 32'd0);
        send_bit("t6_c3", 1'b0); send_bit("t6_c4", 1'b1); send_bit("t6_c5", 1'b1);
        check("t6_full_match", 32'(match_a), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                async_reset("rnd_reset");
            end else begin
                step("rnd",
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 3) == 0),
                     2'($urandom_range(0, 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
